// File: rtl/delay_arbiter.sv
// delay_arbiter: round-robin arbiter feeding a fixed-latency tagged delay pipeline
module delay_arbiter #(
    parameter int WIDTH   = 8,
    parameter int N_REQ   = 4,
    parameter int CLK_DEL = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         hold,
    input  logic [N_REQ-1:0]             req_valid,
    input  logic [N_REQ*WIDTH-1:0]       req_data,
    output logic [N_REQ-1:0]             req_ready,
    output logic [N_REQ-1:0]             resp_valid,
    output logic [WIDTH-1:0]             resp_data,
    output logic [$clog2(CLK_DEL+1)-1:0] inflight,
    output logic                         busy
);
    localparam int IW = $clog2(N_REQ);
    localparam int CW = $clog2(CLK_DEL+1);
    localparam int L  = CLK_DEL - 1;

    logic [IW-1:0]    r_ptr;
    logic [IW-1:0]    w_ptr;
    logic [IW-1:0]    w_gid;
    logic             w_acc;
    logic [L:0]       r_vld;
    logic [IW-1:0]    r_id  [CLK_DEL];
    logic [WIDTH-1:0] r_dat [CLK_DEL];
    logic [CW-1:0]    r_cnt;

    assign w_ptr = rst ? '0 : r_ptr;
    assign w_acc = |req_ready;

    // search from the pointer upward with wrap; the smallest offset that is valid wins
    always_comb begin
        int k;
        k = 0;
        req_ready = '0;
        w_gid = '0;
        for (int j = N_REQ - 1; j >= 0; j--) begin
            k = int'(w_ptr) + j;
            if (k >= N_REQ) k = k - N_REQ;
            if (!hold && req_valid[k]) begin
                req_ready = '0;
                req_ready[k] = 1'b1;
                w_gid = IW'(k);
            end
        end
    end

    // pointer advance, non-stalling {valid,id,data} shift pipeline, in-flight counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
            r_vld <= '0;
            r_cnt <= '0;
            for (int i = 0; i < CLK_DEL; i++) begin
                r_id[i]  <= '0;
                r_dat[i] <= '0;
            end
        end else begin
            if (w_acc) r_ptr <= (w_gid == IW'(N_REQ - 1)) ? '0 : w_gid + 1'b1;
            r_vld[0] <= w_acc;
            r_id[0]  <= w_acc ? w_gid : '0;
            r_dat[0] <= w_acc ? req_data[int'(w_gid)*WIDTH +: WIDTH] : '0;
            for (int i = 1; i < CLK_DEL; i++) begin
                r_vld[i] <= r_vld[i-1];
                r_id[i]  <= r_id[i-1];
                r_dat[i] <= r_dat[i-1];
            end
            r_cnt <= r_cnt + CW'(w_acc) - CW'(r_vld[L]);
        end
    end

    assign resp_valid = r_vld[L] ? (N_REQ'(1) << r_id[L]) : '0;
    assign resp_data  = r_dat[L];
    assign inflight   = r_cnt;
    assign busy       = |r_cnt;
endmodule

// File: tb/tb_delay_arbiter.sv
// tb_delay_arbiter: directed checks of the default build and a CLK_DEL=1, N_REQ=2 build
module tb_delay_arbiter;
    logic        clk = 1'b0;
    logic        rst, hold;
    logic [3:0]  rv, rdy, rsp;
    logic [31:0] rd;
    logic [7:0]  dat;
    logic [1:0]  inf;
    logic        bsy;
    logic        b_hold;
    logic [1:0]  b_rv, b_rdy, b_rsp;
    logic [15:0] b_rd;
    logic [7:0]  b_dat;
    logic        b_inf, b_bsy;
    int          n_vec = 0;
    int          n_err = 0;
    logic [7:0]  dv [4] = '{8'hA0, 8'hB1, 8'hC2, 8'hD3};
    logic [3:0]  wr_v [4] = '{4'b1000, 4'b0101, 4'b0101, 4'b0101};
    int          wr_g [4] = '{3, 0, 2, 0};

    always #5 clk = ~clk;

    delay_arbiter u_a (
        .clk(clk), .rst(rst), .hold(hold), .req_valid(rv), .req_data(rd),
        .req_ready(rdy), .resp_valid(rsp), .resp_data(dat), .inflight(inf), .busy(bsy)
    );

    delay_arbiter #(.WIDTH(8), .N_REQ(2), .CLK_DEL(1)) u_b (
        .clk(clk), .rst(rst), .hold(b_hold), .req_valid(b_rv), .req_data(b_rd),
        .req_ready(b_rdy), .resp_valid(b_rsp), .resp_data(b_dat), .inflight(b_inf), .busy(b_bsy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    initial begin
        rst = 1'b1; hold = 1'b0; rv = '0; rd = '0;
        b_hold = 1'b0; b_rv = '0; b_rd = '0;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_rsp", rsp, 0);
        chk("rst_dat", dat, 0);
        chk("rst_busy", bsy, 0);
        chk("rst_inf", inf, 0);
        chk("rst_rdy", rdy, 0);
        rst = 1'b0; rv = 4'b0001; rd = 32'h0000_00A5;
        #1;
        chk("t1_rdy", rdy, 4'b0001);
        @(negedge clk);
        for (int c = 1; c <= 4; c++) begin
            rv = '0;
            #1;
            chk("t1_inf", inf, (c < 4) ? 1 : 0);
            chk("t1_rsp", rsp, (c == 3) ? 1 : 0);
            chk("t1_dat", dat, (c == 3) ? 8'hA5 : 0);
            @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; rd = {dv[3], dv[2], dv[1], dv[0]};
        for (int c = 0; c < 12; c++) begin
            rv = (c < 8) ? 4'b1111 : 4'b0000;
            #1;
            chk("fair_rdy", rdy, (c < 8) ? (32'(1) << (c % 4)) : 0);
            chk("fair_rsp", rsp, (c >= 3 && c < 11) ? (32'(1) << ((c - 3) % 4)) : 0);
            chk("fair_dat", dat, (c >= 3 && c < 11) ? dv[(c - 3) % 4] : 0);
            chk("fair_inf", inf, (c < 3) ? c : (c <= 8) ? 3 : 11 - c);
            @(negedge clk);
        end
        for (int c = 0; c < 7; c++) begin
            rv = (c < 4) ? wr_v[c] : 4'b0000;
            #1;
            chk("wrap_rdy", rdy, (c < 4) ? (32'(1) << wr_g[c]) : 0);
            chk("wrap_rsp", rsp, (c >= 3) ? (32'(1) << wr_g[c - 3]) : 0);
            chk("wrap_dat", dat, (c >= 3) ? dv[wr_g[c - 3]] : 0);
            @(negedge clk);
        end
        for (int c = 0; c < 9; c++) begin
            rv = 4'b1111; hold = (c >= 4);
            #1;
            chk("hold_rdy", rdy, (c < 4) ? (32'(1) << ((c + 1) % 4)) : 0);
            chk("hold_rsp", rsp, (c >= 3 && c <= 6) ? (32'(1) << ((c - 2) % 4)) : 0);
            chk("hold_dat", dat, (c >= 3 && c <= 6) ? dv[(c - 2) % 4] : 0);
            if (c >= 7) chk("hold_busy", bsy, 0);
            @(negedge clk);
        end
        hold = 1'b0;
        for (int c = 0; c < 8; c++) begin
            rv = (c < 2) ? 4'b0110 : (c == 3) ? 4'b1010 : 4'b0000;
            rst = (c == 2);
            #1;
            if (c < 2) chk("rmid_rdy", rdy, 32'(1) << (c + 1));
            if (c == 2) chk("rmid_inf_pre", inf, 2);
            if (c == 3) chk("rmid_rdy_after", rdy, 4'b0010);
            if (c == 3) chk("rmid_inf_post", inf, 0);
            if (c == 4) chk("rmid_inf_new", inf, 1);
            chk("rmid_rsp", rsp, (c == 6) ? 4'b0010 : 0);
            chk("rmid_dat", dat, (c == 6) ? dv[1] : 0);
            if (c == 7) chk("rmid_busy", bsy, 0);
            @(negedge clk);
        end
        b_rd = {8'h5B, 8'h4A};
        for (int c = 0; c < 8; c++) begin
            b_rv = (c < 6) ? 2'b11 : 2'b00;
            #1;
            chk("b_rdy", b_rdy, (c < 6) ? ((c % 2) ? 2'b10 : 2'b01) : 0);
            chk("b_rsp", b_rsp, (c >= 1 && c <= 6) ? (32'(1) << ((c - 1) % 2)) : 0);
            chk("b_dat", b_dat, (c >= 1 && c <= 6) ? (((c - 1) % 2) ? 8'h5B : 8'h4A) : 0);
            chk("b_inf", b_inf, (c >= 1 && c <= 6) ? 1 : 0);
            @(negedge clk);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
